cam_cfg_sequencer: RTL and testbench
====================================

// Module: cam_cfg_sequencer
// PURPOSE
//  Boot-time configuration sequencer for the MIPI camera sensor. On start it walks a register
//  table held in a synchronous ROM and issues one 16-bit-address / 8-bit-data write per entry
//  to the I2C master that drives SDA/SCL. It honours in-table delay commands, retries
//  NACKed writes and reports done or error.
//  cfg_done_o gates the MIPI-to-parallel receiver reset; the receiver stays in reset until
//  configuration completes.
// PARAMETERS
//  ROM_AW        8      ROM address width; the table holds at most 2**ROM_AW entries
//  DELAY_UNIT    48000  clk_i cycles per delay tick (1 ms at 48 MHz clk_osc)
//  MAX_RETRY     3      re-issues of a NACKed write before entering ERROR (0 = no retry)
// PORTS
//  clk_i         in   1       system clock (clk_osc domain)
//  reset_n_i     in   1       async active-low reset; deassert through reset_bridge
//  start_i       in   1       1-cycle pulse: begin sequence; ignored unless state is IDLE, DONE or ERROR
//  rom_addr_o    out  ROM_AW  table index
//  rom_data_i    in   24      {reg_addr[23:8], reg_data[7:0]}; valid 1 cycle after rom_addr_o
//  i2c_req_o     out  1       write request; held high until i2c_done_i
//  i2c_addr_o    out  16      sensor register address; stable while i2c_req_o is high
//  i2c_data_o    out  8       sensor register data; stable while i2c_req_o is high
//  i2c_done_i    in   1       1-cycle pulse: transaction finished
//  i2c_nack_i    in   1       sampled only when i2c_done_i=1; 1 = sensor NACK
//  busy_o        out  1       high in every state except IDLE, DONE and ERROR
//  cfg_done_o    out  1       high in DONE; drives the MIPI receiver reset release
//  err_o         out  1       high in ERROR
//  err_idx_o     out  ROM_AW  table index of the failing entry; held until next start
// BEHAVIOUR
//  Reset values: state=IDLE, rom_addr_o=0, i2c_req_o=0, i2c_addr_o=0, i2c_data_o=0,
//   busy_o=0, cfg_done_o=0, err_o=0, err_idx_o=0.
//   All outputs are registered; asserting reset_n_i mid-transaction drops i2c_req_o at once.
//  Entry codes, decoded from reg_addr:
//   16'hFFFF = END: go to DONE.
//   16'hFFFE = DELAY: wait reg_data*DELAY_UNIT cycles; reg_data=0 gives no wait.
//   any other value = WRITE.
//  FSM:
//   IDLE  --start_i--> FETCH (rom_addr_o=0, retry counter=0, err_o=0, err_idx_o=0)
//   FETCH  1 cycle; waits for ROM latency -> DECODE
//   DECODE END -> DONE; DELAY -> DLY; WRITE -> REQ (latch addr/data, i2c_req_o=1)
//   REQ   wait for i2c_done_i, then drop i2c_req_o the next cycle:
//     nack=0 -> NEXT
//     nack=1 and retries<MAX_RETRY -> retries+1, re-raise i2c_req_o after one idle cycle
//     nack=1 and retries==MAX_RETRY -> ERROR (err_idx_o=rom_addr_o)
//   DLY   24-bit tick counter + 8-bit unit counter; when expired -> NEXT
//   NEXT  retries=0; if rom_addr_o==2**ROM_AW-1 -> ERROR (no END marker, err_idx_o=that index)
//         else rom_addr_o+1 -> FETCH
//   DONE/ERROR hold their outputs; start_i restarts from FETCH with cfg_done_o/err_o cleared
//  Timing and ordering rules:
//   i2c_done_i outside REQ is ignored. start_i while busy_o is ignored.
//   Minimum time per WRITE entry = 3 cycles plus I2C master latency; no entry is ever skipped.
// TESTING
//  1 Table {3012_01, 0100_01, FFFF_xx}; master acks after 5 cycles
//    -> exactly 2 writes, in order, with addr/data stable while req is high;
//       cfg_done_o rises; busy_o=0.
//  2 Entry FFFE_03 with DELAY_UNIT=10 -> 30 (+/-2) cycles between the two surrounding writes;
//    FFFE_00 -> no added wait.
//  3 NACK on the first 2 attempts of entry 1, ack on the 3rd -> 3 requests with identical
//    addr/data; the sequence completes.
//  4 NACK 4 times with MAX_RETRY=3 -> err_o=1, err_idx_o=1, cfg_done_o=0, no further requests;
//    start_i then replays from index 0.
//  5 Table without END and ROM_AW=2 -> 4 writes, then err_o=1, err_idx_o=3.
//  6 reset_n_i pulsed low while i2c_req_o=1, and start_i pulsed during REQ
//    -> req low asynchronously, all outputs at reset values; the start_i pulse has no effect.

Source files
------------

// File: rtl/cam_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cam_cfg_sequencer
//  Purpose  : Boot-time camera sensor configuration sequencer. Walks a
//             register table held in a synchronous ROM and issues one
//             16-bit-address / 8-bit-data I2C write per entry. It honours
//             in-table delay entries, retries NACKed writes, and reports
//             done or error. cfg_done_o releases the MIPI receiver reset.
//  Ports    : clk_i       system clock
//             reset_n_i   async active-low reset
//             start_i     1-cycle start pulse (IDLE/DONE/ERROR only)
//             rom_addr_o  table index; rom_data_i valid one cycle later
//             rom_data_i  {reg_addr[23:8], reg_data[7:0]}
//             i2c_req_o   write request, held until i2c_done_i
//             i2c_addr_o  sensor register address (stable during request)
//             i2c_data_o  sensor register data (stable during request)
//             i2c_done_i  1-cycle transaction-finished pulse
//             i2c_nack_i  sensor NACK, qualified by i2c_done_i
//             busy_o      sequence in progress
//             cfg_done_o  table completed successfully
//             err_o       sequence aborted
//             err_idx_o   table index of the failing entry
//  Revision : 1.0  initial release
// ============================================================================
module cam_cfg_sequencer #(
  parameter int ROM_AW     = 8,
  parameter int DELAY_UNIT = 48000,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [23:0]       rom_data_i,
  output logic              i2c_req_o,
  output logic [15:0]       i2c_addr_o,
  output logic [7:0]        i2c_data_o,
  input  logic              i2c_done_i,
  input  logic              i2c_nack_i,
  output logic              busy_o,
  output logic              cfg_done_o,
  output logic              err_o,
  output logic [ROM_AW-1:0] err_idx_o
);

  // Retry counter must be at least one bit wide even when retries are disabled.
  localparam int                RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]     MAX_R       = RW'(MAX_RETRY);
  localparam logic [23:0]       TICK_RELOAD = 24'(DELAY_UNIT - 1);
  localparam logic [ROM_AW-1:0] LAST_IDX    = '1;
  localparam logic [15:0]       CODE_END    = 16'hFFFF;
  localparam logic [15:0]       CODE_DELAY  = 16'hFFFE;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REQ    = 4'd3,
    S_GAP    = 4'd4,
    S_DLY    = 4'd5,
    S_NEXT   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  state_t            state_q,    state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              req_q,      req_d;
  logic [15:0]       i2c_addr_q, i2c_addr_d;
  logic [7:0]        i2c_data_q, i2c_data_d;
  logic              busy_q,     busy_d;
  logic              cfg_done_q, cfg_done_d;
  logic              err_q,      err_d;
  logic [ROM_AW-1:0] err_idx_q,  err_idx_d;
  logic [RW-1:0]     retry_q,    retry_d;
  logic [23:0]       tick_q,     tick_d;
  logic [7:0]        unit_q,     unit_d;

  logic [15:0]       entry_addr;
  logic [7:0]        entry_data;

  assign entry_addr = rom_data_i[23:8];
  assign entry_data = rom_data_i[7:0];

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    req_d      = req_q;
    i2c_addr_d = i2c_addr_q;
    i2c_data_d = i2c_data_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    retry_d    = retry_q;
    tick_d     = tick_q;
    unit_d     = unit_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          retry_d    = '0;
          cfg_done_d = 1'b0;
          err_d      = 1'b0;
          err_idx_d  = '0;
        end
      end
      // Address was presented on entry; ROM data is valid in DECODE.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (entry_addr == CODE_END) begin
          state_d    = S_DONE;
          cfg_done_d = 1'b1;
        end else if (entry_addr == CODE_DELAY) begin
          if (entry_data == 8'd0) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_DLY;
            unit_d  = entry_data;
            tick_d  = TICK_RELOAD;
          end
        end else begin
          state_d    = S_REQ;
          i2c_addr_d = entry_addr;
          i2c_data_d = entry_data;
          req_d      = 1'b1;
        end
      end
      S_REQ: begin
        if (i2c_done_i) begin
          req_d = 1'b0;
          if (!i2c_nack_i) begin
            state_d = S_NEXT;
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + RW'(1);
            state_d = S_GAP;
          end else begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            err_idx_d = rom_addr_q;
          end
        end
      end
      // One idle cycle with the request low before re-issuing the same write.
      S_GAP: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      // Total wait is unit count * DELAY_UNIT cycles spent in this state.
      S_DLY: begin
        if (tick_q == 24'd0) begin
          if (unit_q == 8'd1) begin
            state_d = S_NEXT;
          end else begin
            unit_d = unit_q - 8'd1;
            tick_d = TICK_RELOAD;
          end
        end else begin
          tick_d = tick_q - 24'd1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (rom_addr_q == LAST_IDX) begin
          // Ran off the end of the table without an END marker.
          state_d   = S_ERROR;
          err_d     = 1'b1;
          err_idx_d = rom_addr_q;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      req_q      <= 1'b0;
      i2c_addr_q <= 16'd0;
      i2c_data_q <= 8'd0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      retry_q    <= '0;
      tick_q     <= 24'd0;
      unit_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      req_q      <= req_d;
      i2c_addr_q <= i2c_addr_d;
      i2c_data_q <= i2c_data_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      retry_q    <= retry_d;
      tick_q     <= tick_d;
      unit_q     <= unit_d;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign i2c_req_o  = req_q;
  assign i2c_addr_o = i2c_addr_q;
  assign i2c_data_o = i2c_data_q;
  assign busy_o     = busy_q;
  assign cfg_done_o = cfg_done_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_cfg_sequencer
//  Purpose  : Directed self-checking bench for cam_cfg_sequencer with a
//             4-entry table (ROM_AW=2), DELAY_UNIT=10 and MAX_RETRY=3.
//             A behavioural ROM and I2C master (ack latency 5 cycles,
//             programmable NACK run) surround the DUT; every request is
//             logged with its address, data and cycle stamps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  rom_addr;
  logic [23:0] rom_data;
  logic        i2c_req;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data;
  logic        i2c_done;
  logic        i2c_nack;
  logic        busy;
  logic        cfg_done;
  logic        err;
  logic [1:0]  err_idx;

  cam_cfg_sequencer #(.ROM_AW(2), .DELAY_UNIT(10), .MAX_RETRY(3)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .i2c_req_o  (i2c_req),
    .i2c_addr_o (i2c_addr),
    .i2c_data_o (i2c_data),
    .i2c_done_i (i2c_done),
    .i2c_nack_i (i2c_nack),
    .busy_o     (busy),
    .cfg_done_o (cfg_done),
    .err_o      (err),
    .err_idx_o  (err_idx)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one cycle of read latency.
  logic [23:0] rom_tbl [0:3];
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // I2C master model state and request log.
  int          req_cnt, lat_cnt, nack_start, nack_left, stable_err;
  logic        hold, prev_req;
  logic [15:0] log_addr [0:15];
  logic [7:0]  log_data [0:15];
  int          rise_cyc [0:15];
  int          done_cyc [0:15];

  initial begin
    i2c_done = 1'b0; i2c_nack = 1'b0;
    req_cnt = 0; lat_cnt = 0; nack_start = 0; nack_left = 0; stable_err = 0;
    hold = 1'b0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (i2c_req && !prev_req) begin
        if (req_cnt < 16) begin
          log_addr[req_cnt] = i2c_addr;
          log_data[req_cnt] = i2c_data;
          rise_cyc[req_cnt] = cyc;
        end
        req_cnt++;
      end else if (i2c_req && prev_req && req_cnt > 0 && req_cnt <= 16) begin
        if (i2c_addr !== log_addr[req_cnt-1] || i2c_data !== log_data[req_cnt-1]) stable_err++;
      end
      if (i2c_req && !hold) begin
        lat_cnt++;
        if (lat_cnt == 5) begin
          i2c_done = 1'b1;
          if ((req_cnt - 1) >= nack_start && nack_left > 0) begin
            i2c_nack = 1'b1;
            nack_left--;
          end
          if (req_cnt > 0 && req_cnt <= 16) done_cyc[req_cnt-1] = cyc;
          hold    = 1'b1;
          lat_cnt = 0;
        end
      end else if (!i2c_req) begin
        lat_cnt = 0;
        hold    = 1'b0;
      end
      prev_req = i2c_req;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log(input int n_start, input int n_left);
    req_cnt    = 0;
    stable_err = 0;
    nack_start = n_start;
    nack_left  = n_left;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(cfg_done || err) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic load_tbl(input logic [23:0] e0, input logic [23:0] e1,
                          input logic [23:0] e2, input logic [23:0] e3);
    rom_tbl[0] = e0; rom_tbl[1] = e1; rom_tbl[2] = e2; rom_tbl[3] = e3;
  endtask

  int gap_base, gap0, gap3, n;
  int saved_cnt;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    load_tbl(24'h3012_01, 24'h0100_01, 24'hFFFF_00, 24'h0000_00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_req",      {31'd0, i2c_req}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_flags",    {29'd0, cfg_done, err, |err_idx}, 32'd0);
    check("rst_addr_bus", {rom_addr, i2c_addr, i2c_data}, 32'd0);

    // 1: basic two-write table
    clear_log(99, 0);
    pulse_start();
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    wait_end("t1");
    check("t1_req_count", req_cnt, 32'd2);
    check("t1_w0", {log_addr[0], log_data[0]}, 32'h3012_01);
    check("t1_w1", {log_addr[1], log_data[1]}, 32'h0100_01);
    check("t1_stable", stable_err, 32'd0);
    check("t1_done_busy_err", {29'd0, cfg_done, busy, err}, 32'b100);
    gap_base = rise_cyc[1] - done_cyc[0];

    // 2a: delay of 3 units between writes
    load_tbl(24'h1111_AA, 24'hFFFE_03, 24'h2222_BB, 24'hFFFF_00);
    clear_log(99, 0);
    pulse_start();
    wait_end("t2a");
    check("t2a_req_count", req_cnt, 32'd2);
    check("t2a_w1", {log_addr[1], log_data[1]}, 32'h2222_BB);
    gap3 = rise_cyc[1] - done_cyc[0];

    // 2b: zero delay entry
    load_tbl(24'h1111_AA, 24'hFFFE_00, 24'h2222_BB, 24'hFFFF_00);
    clear_log(99, 0);
    pulse_start();
    wait_end("t2b");
    check("t2b_done", {31'd0, cfg_done}, 32'd1);
    gap0 = rise_cyc[1] - done_cyc[0];
    check("t2_delay30", {31'd0, ((gap3 - gap0) >= 28) && ((gap3 - gap0) <= 32)}, 32'd1);
    check("t2_zero_delay", {31'd0, (gap0 - gap_base) <= 4}, 32'd1);

    // 3: two NACKs on entry 1 then ack
    load_tbl(24'h3012_01, 24'h4444_55, 24'hFFFF_00, 24'h0000_00);
    clear_log(1, 2);
    pulse_start();
    wait_end("t3");
    check("t3_req_count", req_cnt, 32'd4);
    check("t3_try1", {log_addr[1], log_data[1]}, 32'h4444_55);
    check("t3_try2", {log_addr[2], log_data[2]}, 32'h4444_55);
    check("t3_try3", {log_addr[3], log_data[3]}, 32'h4444_55);
    check("t3_done_err", {30'd0, cfg_done, err}, 32'b10);
    check("t3_stable", stable_err, 32'd0);

    // 4: four NACKs exhaust retries
    clear_log(1, 4);
    pulse_start();
    wait_end("t4");
    check("t4_req_count", req_cnt, 32'd5);
    check("t4_flags", {29'd0, err, cfg_done, busy}, 32'b100);
    check("t4_err_idx", {30'd0, err_idx}, 32'd1);
    repeat (20) @(negedge clk);
    check("t4_no_more_req", req_cnt, 32'd5);
    clear_log(99, 0);
    pulse_start();
    check("t4_restart_state", {27'd0, busy, err, cfg_done, rom_addr}, 32'b10000);
    check("t4_restart_idx", {30'd0, err_idx}, 32'd0);
    wait_end("t4r");
    check("t4_replay", {req_cnt[7:0], log_addr[0], log_data[0]}, 32'h02_3012_01);
    check("t4_replay_done", {31'd0, cfg_done}, 32'd1);

    // 5: table without END marker
    load_tbl(24'h0001_11, 24'h0002_22, 24'h0003_33, 24'h0004_44);
    clear_log(99, 0);
    pulse_start();
    wait_end("t5");
    check("t5_req_count", req_cnt, 32'd4);
    check("t5_w0", {log_addr[0], log_data[0]}, 32'h0001_11);
    check("t5_w3", {log_addr[3], log_data[3]}, 32'h0004_44);
    check("t5_err", {29'd0, err, cfg_done, busy}, 32'b100);
    check("t5_err_idx", {30'd0, err_idx}, 32'd3);

    // 6: start ignored during REQ, then async reset mid-transaction
    load_tbl(24'h3012_01, 24'h0100_01, 24'hFFFF_00, 24'h0000_00);
    clear_log(99, 0);
    pulse_start();
    n = 0;
    while (!i2c_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_req_seen", {31'd0, i2c_req}, 32'd1);
    pulse_start();
    check("t6_start_ignored", {29'd0, i2c_req, busy, |rom_addr}, 32'b110);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, i2c_req}, 32'd0);
    check("t6_async_outs", {rom_addr, i2c_addr, i2c_data, busy, cfg_done, err, err_idx}, 32'd0);
    hold = 1'b0; lat_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    saved_cnt = req_cnt;
    repeat (20) @(negedge clk);
    check("t6_idle_after", {30'd0, busy, i2c_req}, 32'd0);
    check("t6_no_req", req_cnt, saved_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
